// File: rtl/simd_pkg.sv
// Shared SIMD definitions: lane geometry defaults, a lane-slice helper,
// the op encodings used by the ALU stage, and the accumulator state enum.
package simd_pkg;

    localparam int N_DEF  = 4;
    localparam int L_DEF  = 16;
    localparam int CW_DEF = 8;
    localparam int W_DEF  = N_DEF * L_DEF;

    // Op encodings shared with the upstream vector/scalar ALU stage
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_PASS = 3'd6
    } simd_op_t;

    // ACC collects beats of a burst, HOLD presents the finished sum
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    // Extract lane idx from a default-geometry packed vector
    function automatic logic [L_DEF-1:0] lane_of(input logic [W_DEF-1:0] vec, input int idx);
        return vec[idx*L_DEF +: L_DEF];
    endfunction

endpackage

// File: rtl/simd_acc_lane.sv
// One accumulator lane: either loads the incoming lane (first beat of a
// burst) or adds it to the running lane sum. Under SIMD_ACC_SAT_EN the add
// is signed saturating and reports an overflow; otherwise it wraps mod 2^L.
module simd_acc_lane #(
    parameter int L = 16
) (
    input  logic         load,
    input  logic [L-1:0] acc,
    input  logic [L-1:0] din,
`ifdef SIMD_ACC_SAT_EN
    output logic         ovf,
`endif
    output logic [L-1:0] sum
);

`ifdef SIMD_ACC_SAT_EN
    logic [L:0] wide;

    // Sign-extended add; a disagreement between the top two bits means overflow
    always_comb begin
        wide = {acc[L-1], acc} + {din[L-1], din};
        sum  = wide[L-1:0];
        ovf  = 1'b0;
        if (load) begin
            sum = din;
        end else if (wide[L] != wide[L-1]) begin
            ovf = 1'b1;
            sum = wide[L] ? {1'b1, {(L-1){1'b0}}} : {1'b0, {(L-1){1'b1}}};
        end
    end
`else
    // Plain modulo-2^L add, matching the wrap arithmetic upstream
    always_comb begin
        sum = load ? din : acc + din;
    end
`endif

endmodule

// File: rtl/simd_accumulator.sv
// Streaming element-wise accumulator: sums N independent L-bit lanes over a
// burst closed by in_last and hands one result per burst downstream.
// Optional feature macro: SIMD_ACC_SAT_EN (signed saturating lanes + out_sat).
module simd_accumulator
    import simd_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int L  = L_DEF,
    parameter  int CW = CW_DEF,
    localparam int W  = N * L
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
`ifdef SIMD_ACC_SAT_EN
    output logic          out_sat,
`endif
    output logic [CW-1:0] out_beats
);

    acc_state_t    state;
    acc_state_t    next_state;
    logic [W-1:0]  acc;
    logic [W-1:0]  lane_sum;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          first;
    logic          accept;
    logic          emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // The first beat restarts the count; later beats saturate at all-ones
    assign next_count = first ? CW'(1) : ((&count) ? count : count + CW'(1));

`ifdef SIMD_ACC_SAT_EN
    logic [N-1:0] lane_ovf;
    logic         burst_sat;
    logic         burst_sat_next;

    assign burst_sat_next = (first ? 1'b0 : burst_sat) | (|lane_ovf);
`endif

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            simd_acc_lane #(.L(L)) u_lane (
                .load (first),
                .acc  (acc[g*L +: L]),
                .din  (in_data[g*L +: L]),
`ifdef SIMD_ACC_SAT_EN
                .ovf  (lane_ovf[g]),
`endif
                .sum  (lane_sum[g*L +: L])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= next_state;
    end

    // Leave ACC on the accepted last beat, leave HOLD once the result is taken
    always_comb begin
        next_state = state;
        case (state)
            ACC:     if (accept && in_last) next_state = HOLD;
            HOLD:    if (emit)              next_state = ACC;
            default: next_state = ACC;
        endcase
    end

    // Upstream may only push while collecting, and never during reset
    always_comb begin
        in_ready = (state == ACC) && !rst;
    end

    // Running sums, beat count and the registered result presented downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
`ifdef SIMD_ACC_SAT_EN
            burst_sat <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                acc   <= lane_sum;
                count <= next_count;
                first <= 1'b0;
`ifdef SIMD_ACC_SAT_EN
                burst_sat <= burst_sat_next;
`endif
                if (in_last) begin
                    out_data  <= lane_sum;
                    out_beats <= next_count;
                    out_valid <= 1'b1;
                    first     <= 1'b1;
`ifdef SIMD_ACC_SAT_EN
                    out_sat   <= burst_sat_next;
`endif
                end
            end
            if (emit) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simd_accumulator.sv
// Directed self-checking bench for simd_accumulator (N=4, L=16, CW=8).
// Builds with or without SIMD_ACC_SAT_EN; expectations follow the macro.
module tb_simd_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_beats;
`ifdef SIMD_ACC_SAT_EN
    logic        out_sat;
`endif

    int totalCount;
    int badCount;

    simd_accumulator #(.N(4), .L(16), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SIMD_ACC_SAT_EN
        .out_sat   (out_sat),
`endif
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane 0 is the least significant slice
    function automatic logic [63:0] packLanes(input logic [15:0] l0, input logic [15:0] l1,
                                              input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one beat and hold it until it is accepted; returns #1 after the accepting edge
    task automatic applyStimulus(input logic [63:0] data, input logic last);
        int waitCount;
        waitCount = 0;
        @(negedge clk);
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
        end
        if (!in_ready) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_beats", 64'(out_beats), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Three-beat burst
        $display("[TB] three-beat burst");
        applyStimulus(packLanes(1, 2, 3, 4), 1'b0);
        checkOutput("b3_no_early_valid", 64'(out_valid), 64'd0);
        applyStimulus(packLanes(10, 20, 30, 40), 1'b0);
        applyStimulus(packLanes(100, 200, 300, 400), 1'b1);
        checkOutput("b3_out_valid", 64'(out_valid), 64'd1);
        checkOutput("b3_out_data", out_data, packLanes(111, 222, 333, 444));
        checkOutput("b3_out_beats", 64'(out_beats), 64'd3);
        checkOutput("b3_hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("b3_valid_one_cycle", 64'(out_valid), 64'd0);
        checkOutput("b3_ready_after_emit", 64'(in_ready), 64'd1);

        // Lane add overflow: wraps without the macro, clamps with it
        $display("[TB] lane overflow");
        applyStimulus(packLanes(16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001), 1'b0);
        applyStimulus(packLanes(16'h0002, 16'h0001, 16'hFFFF, 16'h0002), 1'b1);
`ifdef SIMD_ACC_SAT_EN
        checkOutput("ovf_out_data", out_data, packLanes(16'h0001, 16'h7FFF, 16'h8000, 16'h0003));
        checkOutput("ovf_out_sat", 64'(out_sat), 64'd1);
`else
        checkOutput("ovf_out_data", out_data, packLanes(16'h0001, 16'h8000, 16'h7FFF, 16'h0003));
`endif
        checkOutput("ovf_out_beats", 64'(out_beats), 64'd2);
        @(posedge clk);
        #1;

`ifdef SIMD_ACC_SAT_EN
        // Sticky flag must clear on a clean burst
        applyStimulus(packLanes(1, 1, 1, 1), 1'b1);
        checkOutput("clean_out_sat", 64'(out_sat), 64'd0);
        @(posedge clk);
        #1;
`endif

        // Backpressure: result held, new beats refused
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(packLanes(1, 1, 1, 1), 1'b0);
        applyStimulus(packLanes(2, 2, 2, 2), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = packLanes(50, 50, 50, 50);
            in_last  = 1'b1;
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_out_data", out_data, packLanes(3, 3, 3, 3));
            checkOutput("bp_out_beats", 64'(out_beats), 64'd2);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_emit_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_data_held", out_data, packLanes(3, 3, 3, 3));

        // Single-beat burst, also proves a fresh sum after backpressure
        $display("[TB] single-beat burst");
        applyStimulus(packLanes(5, 6, 7, 8), 1'b1);
        checkOutput("single_out_valid", 64'(out_valid), 64'd1);
        checkOutput("single_out_data", out_data, packLanes(5, 6, 7, 8));
        checkOutput("single_out_beats", 64'(out_beats), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a burst
        $display("[TB] mid-burst reset");
        applyStimulus(packLanes(20, 20, 20, 20), 1'b0);
        applyStimulus(packLanes(30, 30, 30, 30), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_out_data", out_data, 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(packLanes(9, 9, 9, 9), 1'b1);
        checkOutput("after_rst_out_data", out_data, packLanes(9, 9, 9, 9));
        checkOutput("after_rst_out_beats", 64'(out_beats), 64'd1);
        @(posedge clk);
        #1;

        // Long burst: beat counter saturates, lane sums keep counting
        $display("[TB] 300-beat burst");
        for (int i = 0; i < 299; i++) begin
            applyStimulus(packLanes(1, 1, 1, 1), 1'b0);
        end
        applyStimulus(packLanes(1, 1, 1, 1), 1'b1);
        checkOutput("long_out_valid", 64'(out_valid), 64'd1);
        checkOutput("long_out_data", out_data, packLanes(300, 300, 300, 300));
        checkOutput("long_out_beats", 64'(out_beats), 64'd255);
        @(posedge clk);
        #1;
        checkOutput("long_emit_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
